uart_frame_decoder: RTL and testbench
=====================================

// Module: uart_frame_decoder
// PURPOSE
//  Sits directly downstream of the UART receiver and consumes its data/ready byte strobes.
//  Hunts for a sync byte, then reads the length byte, the payload and an XOR checksum.
//  Each byte is one rx_ready strobe. Frame format: SYNC, LEN, payload[LEN], CHK.
//  Buffers the payload. Once the checksum verifies, replays the payload as a valid/ready byte stream.
//  Malformed, stalled and overrun frames are discarded. Each one raises a single-cycle error pulse.
// PARAMETERS
//  CLOCK_FREQ      50000000                     system clock in Hz
//  BAUD_RATE       9600                         line rate in baud; used only to size the timeout
//  SYNC_BYTE       8'hA5                        start-of-frame marker
//  MAX_LEN         16                           maximum payload length in bytes (1..255)
//  TIMEOUT_CYCLES  (CLOCK_FREQ/BAUD_RATE)*20    idle cycles allowed between bytes inside a frame
// PORTS
//  clk        in   1  system clock; the block has one clock
//  reset      in   1  synchronous, active-high reset
//  rx_data    in   8  byte from the UART receiver; sampled only when rx_ready=1
//  rx_ready   in   1  one-cycle strobe marking rx_data as valid
//  out_data   out  8  payload byte
//  out_valid  out  1  out_data is valid
//  out_ready  in   1  downstream accepts; a transfer occurs when out_valid & out_ready
//  out_last   out  1  marks the final payload byte of the frame
//  frame_err  out  1  one-cycle pulse when a frame is discarded
//  err_code   out  2  0=BAD_LEN 1=BAD_CHK 2=TIMEOUT 3=OVERRUN; holds its value until the next error
// BEHAVIOUR
//  Reset (synchronous, highest priority, legal in any state):
//   - state=HUNT; out_valid=0, out_last=0, frame_err=0, err_code=0, out_data=0.
//   - len, idx, rd_idx, chk and the timeout counter clear; any partial frame is dropped.
//  States: HUNT, LEN, PAYLOAD, CHECK, DRAIN. All transitions happen on the strobe cycle.
//  HUNT:
//   - rx_ready with rx_data==SYNC_BYTE -> LEN.
//   - Every other byte is silently ignored.
//  LEN:
//   - Byte 0 or byte > MAX_LEN -> pulse frame_err with BAD_LEN, go to HUNT.
//   - Otherwise set len=byte, chk=byte, idx=0, go to PAYLOAD.
//  PAYLOAD:
//   - Each byte: buf[idx]=byte, chk^=byte, idx++.
//   - Byte with idx==len-1 -> CHECK.
//   - A byte equal to SYNC_BYTE is treated as data; there is no resync mid-frame.
//  CHECK:
//   - Byte==chk -> DRAIN with rd_idx=0; out_valid is 1 the cycle after the strobe.
//   - Otherwise pulse BAD_CHK and go to HUNT.
//  DRAIN:
//   - out_valid=1, out_data=buf[rd_idx], out_last=(rd_idx==len-1).
//   - out_data and out_last hold stable while out_valid & !out_ready.
//   - Each transfer increments rd_idx. The transfer with out_last=1 -> HUNT; out_valid is 0 the next cycle.
//   - rx_ready during DRAIN: the byte is dropped and OVERRUN pulses. The state and the drain are unaffected.
//  Timeout (LEN/PAYLOAD/CHECK only):
//   - Counter clears on every rx_ready and increments otherwise.
//   - Reaching TIMEOUT_CYCLES -> pulse TIMEOUT, go to HUNT.
//   - If a strobe arrives on the expiry cycle, the strobe wins.
//   - The counter is held at 0 in HUNT and DRAIN.
//  Error outputs:
//   - frame_err is registered and high for exactly one cycle per error.
//   - err_code updates on the same cycle frame_err pulses.
//  Widths:
//   - Counter width is $clog2(TIMEOUT_CYCLES+1).
//   - idx and rd_idx width is $clog2(MAX_LEN+1).
//   - The checksum is the 8-bit XOR of LEN and all payload bytes.
//  Throughput: a strobe may arrive on every cycle; no byte is lost outside DRAIN.
// TESTING
//  1. Strobe A5 03 11 22 33 03 -> out_data 11,22,33 with out_valid; out_last only on 33; frame_err never pulses.
//  2. Same frame with out_ready low for 5 cycles before each byte -> data held stable, all 3 bytes delivered in order.
//  3. A5 03 11 22 33 04 -> no out_valid; one frame_err pulse with err_code=1; state returns to HUNT.
//  4. A5 00, then A5 11 (MAX_LEN=16) -> two pulses, each with err_code=0; a following valid frame decodes correctly.
//  5. A5 03 11, then silence for TIMEOUT_CYCLES -> one pulse with err_code=2; a following valid frame decodes correctly.
//  6. Byte strobed during DRAIN of frame 1 -> pulse with err_code=3, frame 1 still delivered intact.
//  7. reset asserted mid-PAYLOAD -> outputs return to reset values; garbage bytes 00 FF are ignored; the next A5 frame decodes.

Source files
------------

// File: rtl/uart_frame_decoder.sv
// Frame decoder behind a UART receiver: SYNC, LEN, payload, XOR checksum.
// Verified payloads are replayed as a valid/ready byte stream.
module uart_frame_decoder #(
    parameter int         CLOCK_FREQ     = 50000000,
    parameter int         BAUD_RATE      = 9600,
    parameter logic [7:0] SYNC_BYTE      = 8'hA5,
    parameter int         MAX_LEN        = 16,
    parameter int         TIMEOUT_CYCLES = (CLOCK_FREQ / BAUD_RATE) * 20
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] rx_data,
    input  logic       rx_ready,
    output logic [7:0] out_data,
    output logic       out_valid,
    input  logic       out_ready,
    output logic       out_last,
    output logic       frame_err,
    output logic [1:0] err_code
);
    localparam int IW = $clog2(MAX_LEN + 1);
    localparam int AW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [7:0] MAXB = 8'(MAX_LEN);
    localparam logic [1:0] E_BAD_LEN = 2'd0;
    localparam logic [1:0] E_BAD_CHK = 2'd1;
    localparam logic [1:0] E_TIMEOUT = 2'd2;
    localparam logic [1:0] E_OVERRUN = 2'd3;

    typedef enum logic [2:0] {
        S_HUNT, S_LEN, S_PAYLOAD, S_CHECK, S_DRAIN
    } state_t;

    state_t        state_q, state_d;
    logic [7:0]    len_q, len_d;
    logic [7:0]    chk_q, chk_d;
    logic [IW-1:0] idx_q, idx_d;
    logic [IW-1:0] rd_q, rd_d;
    logic [CW-1:0] tmo_q, tmo_d;
    logic [7:0]    dat_q, dat_d;
    logic          vld_q, vld_d;
    logic          last_q, last_d;
    logic          err_q, err_d;
    logic [1:0]    code_q, code_d;
    logic [7:0]    mem_q [MAX_LEN];
    logic          wr_en;
    logic          xfer;
    logic          tmo_hit;
    logic [IW-1:0] rd_nxt;

    always_comb begin
        state_d = state_q;
        len_d   = len_q;
        chk_d   = chk_q;
        idx_d   = idx_q;
        rd_d    = rd_q;
        tmo_d   = '0;
        dat_d   = dat_q;
        vld_d   = vld_q;
        last_d  = last_q;
        err_d   = 1'b0;
        code_d  = code_q;
        wr_en   = 1'b0;
        tmo_hit = 1'b0;
        xfer    = vld_q & out_ready;
        rd_nxt  = rd_q + IW'(1);

        // idle time only counts while a frame is partially received
        if (state_q inside {S_LEN, S_PAYLOAD, S_CHECK} && !rx_ready) begin
            tmo_d   = tmo_q + CW'(1);
            tmo_hit = (tmo_d == CW'(TIMEOUT_CYCLES));
        end

        unique case (state_q)
            S_HUNT: begin
                if (rx_ready && rx_data == SYNC_BYTE) state_d = S_LEN;
            end
            S_LEN: begin
                if (rx_ready) begin
                    if (rx_data == 8'd0 || rx_data > MAXB) begin
                        err_d   = 1'b1;
                        code_d  = E_BAD_LEN;
                        state_d = S_HUNT;
                    end else begin
                        len_d   = rx_data;
                        chk_d   = rx_data;
                        idx_d   = '0;
                        state_d = S_PAYLOAD;
                    end
                end
            end
            S_PAYLOAD: begin
                if (rx_ready) begin
                    wr_en = 1'b1;
                    chk_d = chk_q ^ rx_data;
                    idx_d = idx_q + IW'(1);
                    if (8'(idx_q) == len_q - 8'd1) state_d = S_CHECK;
                end
            end
            S_CHECK: begin
                if (rx_ready) begin
                    if (rx_data == chk_q) begin
                        state_d = S_DRAIN;
                        rd_d    = '0;
                        vld_d   = 1'b1;
                        dat_d   = mem_q[0];
                        last_d  = (len_q == 8'd1);
                    end else begin
                        err_d   = 1'b1;
                        code_d  = E_BAD_CHK;
                        state_d = S_HUNT;
                    end
                end
            end
            S_DRAIN: begin
                if (rx_ready) begin
                    err_d  = 1'b1;
                    code_d = E_OVERRUN;
                end
                if (xfer) begin
                    if (last_q) begin
                        vld_d   = 1'b0;
                        last_d  = 1'b0;
                        rd_d    = '0;
                        state_d = S_HUNT;
                    end else begin
                        rd_d   = rd_nxt;
                        dat_d  = mem_q[AW'(rd_nxt)];
                        last_d = (8'(rd_nxt) == len_q - 8'd1);
                    end
                end
            end
            default: state_d = S_HUNT;
        endcase

        if (tmo_hit) begin
            err_d   = 1'b1;
            code_d  = E_TIMEOUT;
            state_d = S_HUNT;
            tmo_d   = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_HUNT;
            len_q   <= '0;
            chk_q   <= '0;
            idx_q   <= '0;
            rd_q    <= '0;
            tmo_q   <= '0;
            dat_q   <= '0;
            vld_q   <= 1'b0;
            last_q  <= 1'b0;
            err_q   <= 1'b0;
            code_q  <= '0;
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            chk_q   <= chk_d;
            idx_q   <= idx_d;
            rd_q    <= rd_d;
            tmo_q   <= tmo_d;
            dat_q   <= dat_d;
            vld_q   <= vld_d;
            last_q  <= last_d;
            err_q   <= err_d;
            code_q  <= code_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) mem_q[AW'(idx_q)] <= rx_data;
    end

    assign out_data  = dat_q;
    assign out_valid = vld_q;
    assign out_last  = last_q;
    assign frame_err = err_q;
    assign err_code  = code_q;

endmodule

// File: tb/tb_uart_frame_decoder.sv
// Randomised and directed bench for uart_frame_decoder against a
// byte-queue reference model of the frame rules.
module tb_uart_frame_decoder;
    localparam int         CF   = 1000;
    localparam int         BR   = 100;
    localparam int         TMO  = (CF / BR) * 20;
    localparam logic [7:0] SYNC = 8'hA5;
    localparam int         MAXL = 16;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] rx_data = 8'h00;
    logic       rx_ready = 1'b0;
    logic [7:0] out_data;
    logic       out_valid;
    logic       out_ready;
    logic       out_last;
    logic       frame_err;
    logic [1:0] err_code;

    uart_frame_decoder #(
        .CLOCK_FREQ(CF), .BAUD_RATE(BR), .SYNC_BYTE(SYNC), .MAX_LEN(MAXL)
    ) dut (
        .clk(clk), .reset(reset), .rx_data(rx_data), .rx_ready(rx_ready),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .out_last(out_last), .frame_err(frame_err), .err_code(err_code)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // reference model: partial frame bytes, pending output bytes
    logic [7:0] mf[$];
    logic [7:0] mq[$];
    int         m_idle = 0;
    logic       m_err = 1'b0;
    logic [1:0] m_code = 2'd0;

    logic [8:0] got[$];
    logic [1:0] errlog[$];

    function automatic void model_step();
        logic [7:0] x;
        m_err = 1'b0;
        if (reset) begin
            mf.delete();
            mq.delete();
            m_idle = 0;
            m_code = 2'd0;
            return;
        end
        if (mq.size() != 0) begin
            if (out_ready) mq.delete(0);
            if (rx_ready) begin
                m_err = 1'b1;
                m_code = 2'd3;
            end
        end else if (rx_ready) begin
            m_idle = 0;
            if (mf.size() != 0 || rx_data == SYNC) mf.push_back(rx_data);
            if (mf.size() == 2 && (mf[1] == 8'd0 || int'(mf[1]) > MAXL)) begin
                m_err = 1'b1;
                m_code = 2'd0;
                mf.delete();
            end else if (mf.size() > 2 && mf.size() == int'(mf[1]) + 3) begin
                x = 8'h00;
                for (int i = 1; i < mf.size() - 1; i++) x ^= mf[i];
                if (x == mf[mf.size() - 1]) begin
                    for (int i = 2; i < mf.size() - 1; i++) mq.push_back(mf[i]);
                end else begin
                    m_err = 1'b1;
                    m_code = 2'd1;
                end
                mf.delete();
            end
        end else if (mf.size() != 0) begin
            m_idle++;
            if (m_idle == TMO) begin
                m_err = 1'b1;
                m_code = 2'd2;
                mf.delete();
                m_idle = 0;
            end
        end
    endfunction

    always @(posedge clk) begin
        if (!reset && out_valid && out_ready) got.push_back({out_last, out_data});
        model_step();
        #1;
        check("frame_err", frame_err, m_err);
        check("err_code", err_code, m_code);
        check("out_valid", out_valid, mq.size() != 0);
        if (mq.size() != 0) begin
            check("out_data", out_data, mq[0]);
            check("out_last", out_last, mq.size() == 1);
        end else begin
            check("out_last_idle", out_last, 1'b0);
        end
        if (frame_err) errlog.push_back(err_code);
    end

    // 0: always ready, 1: random, 2: five low cycles then one high
    int rmode = 0;
    int rcnt = 0;
    always @(negedge clk) begin
        rcnt = (rcnt + 1) % 6;
        case (rmode)
            0: out_ready = 1'b1;
            1: out_ready = 1'($urandom_range(0, 1));
            default: out_ready = (rcnt == 5);
        endcase
    end

    task automatic send(input logic [7:0] b);
        rx_data = b;
        rx_ready = 1'b1;
        @(negedge clk);
        rx_ready = 1'b0;
        rx_data = 8'($urandom);
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_done();
        int n = 0;
        while ((mq.size() != 0 || mf.size() != 0) && n < 5000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 5000) check("wait_bound", 0, 1);
        idle(2);
    endtask

    task automatic clr();
        got.delete();
        errlog.delete();
    endtask

    function automatic int pick_gap();
        int v = int'($urandom_range(0, 39));
        if (v < 30) return v % 3;
        if (v < 37) return 3 + v % 4;
        if (v < 39) return TMO - 1;
        return TMO;
    endfunction

    task automatic send_frame1();
        send(SYNC); send(8'h03); send(8'h11);
        send(8'h22); send(8'h33); send(8'h03);
    endtask

    task automatic check_frame1(input string tag);
        check({tag, "_n"}, got.size(), 3);
        check({tag, "_b0"}, got[0], 9'h011);
        check({tag, "_b1"}, got[1], 9'h022);
        check({tag, "_b2"}, got[2], 9'h133);
    endtask

    initial begin
        int len;
        logic [7:0] b, x;
        reset = 1'b1;
        idle(3);
        check("rst_data", out_data, 8'h00);
        check("rst_code", err_code, 2'd0);
        reset = 1'b0;
        idle(2);

        clr(); send_frame1(); wait_done();
        check_frame1("t1");
        check("t1_err", errlog.size(), 0);

        clr(); rmode = 2; send_frame1(); wait_done(); rmode = 0;
        check_frame1("t2");

        clr();
        send(SYNC); send(8'h03); send(8'h11);
        send(8'h22); send(8'h33); send(8'h04); wait_done();
        check("t3_n", got.size(), 0);
        check("t3_e", errlog.size(), 1);
        check("t3_code", errlog[0], 2'd1);

        clr();
        send(SYNC); send(8'h00); send(SYNC); send(8'h11);
        send(SYNC); send(8'h01); send(8'h7E); send(8'h7F); wait_done();
        check("t4_e", errlog.size(), 2);
        check("t4_c0", errlog[0], 2'd0);
        check("t4_c1", errlog[1], 2'd0);
        check("t4_n", got.size(), 1);
        check("t4_b0", got[0], 9'h17E);

        clr();
        send(SYNC); send(8'h03); send(8'h11); idle(TMO + 5);
        send_frame1(); wait_done();
        check("t5_e", errlog.size(), 1);
        check("t5_code", errlog[0], 2'd2);
        check_frame1("t5");

        clr();
        send(SYNC); send(8'h02); idle(TMO - 1);
        send(8'hC3); idle(TMO - 1); send(8'h3C); send(8'hFD); wait_done();
        check("t5b_e", errlog.size(), 0);
        check("t5b_n", got.size(), 2);
        check("t5b_b1", got[1], 9'h13C);

        clr(); rmode = 2;
        send(SYNC); send(8'h02); send(8'hC3); send(8'h3C); send(8'hFD);
        idle(1); send(8'h55); wait_done(); rmode = 0;
        check("t6_e", errlog.size(), 1);
        check("t6_code", errlog[0], 2'd3);
        check("t6_n", got.size(), 2);
        check("t6_b0", got[0], 9'h0C3);
        check("t6_b1", got[1], 9'h13C);

        clr();
        send(SYNC); send(8'h03); send(8'h11);
        reset = 1'b1; idle(1);
        check("t7_data", out_data, 8'h00);
        check("t7_code", err_code, 2'd0);
        reset = 1'b0;
        send(8'h00); send(8'hFF); send_frame1(); wait_done();
        check_frame1("t7");
        check("t7_e", errlog.size(), 0);

        rmode = 1;
        for (int k = 0; k < 80; k++) begin
            int r = int'($urandom_range(0, 9));
            if (r == 0) begin
                send(8'($urandom));
                continue;
            end
            if (r < 2) len = int'($urandom_range(0, 2)) == 0 ? 0 : 17;
            else len = int'($urandom_range(1, MAXL));
            send(SYNC); idle(pick_gap());
            send(8'(len));
            if (len == 0 || len > MAXL) continue;
            x = 8'(len);
            for (int i = 0; i < len; i++) begin
                b = 8'($urandom);
                x ^= b;
                idle(pick_gap());
                send(b);
            end
            if ($urandom_range(0, 4) == 0) x ^= 8'h01 << $urandom_range(0, 7);
            idle(pick_gap());
            send(x);
            if ($urandom_range(0, 1) == 0) wait_done();
        end
        wait_done();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
